// File: rtl/pong_pkg.sv
// Shared Pong definitions: ball FSM state encoding and default playfield geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0] DEF_V         = 8'd2;
  localparam logic [7:0] DEF_BALL_SIZE = 8'd8;
  localparam logic [7:0] DEF_TOP_Y     = 8'd8;
  localparam logic [7:0] DEF_BOT_Y     = 8'd247;
  localparam logic [7:0] DEF_LEFT_X    = 8'd8;
  localparam logic [7:0] DEF_PAD_XL    = 8'd240;
  localparam logic [7:0] DEF_PAD_XR    = 8'd243;
  localparam logic [7:0] DEF_MISS_X    = 8'd250;
  localparam logic [7:0] DEF_CENTER_X  = 8'd124;
  localparam logic [7:0] DEF_CENTER_Y  = 8'd124;
  localparam int         DEF_SERVE_TICKS = 4;

  // Far edge of the ball (pos + size - 1), saturated so it still fits the 8-bit comparators.
  function automatic logic [7:0] farEdge(input logic [7:0] pos, input logic [7:0] size);
    logic [8:0] sum;
    sum = {1'b0, pos} + {1'b0, size} - 9'd1;
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/comp_gt8.sv
// Unsigned 8-bit greater-than comparator shared by the ball engine range checks.
module comp_gt8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_gt
);

  assign o_gt = (i_a > i_b);

endmodule

// File: rtl/ball_mover.sv
// Pong ball engine: serves, moves and bounces the ball once per frame tick and
// reports paddle hits and misses as single-cycle pulses.
module ball_mover
  import pong_pkg::*;
#(
  parameter logic [7:0] V           = DEF_V,
  parameter logic [7:0] BALL_SIZE   = DEF_BALL_SIZE,
  parameter logic [7:0] TOP_Y       = DEF_TOP_Y,
  parameter logic [7:0] BOT_Y       = DEF_BOT_Y,
  parameter logic [7:0] LEFT_X      = DEF_LEFT_X,
  parameter logic [7:0] PAD_XL      = DEF_PAD_XL,
  parameter logic [7:0] PAD_XR      = DEF_PAD_XR,
  parameter logic [7:0] MISS_X      = DEF_MISS_X,
  parameter logic [7:0] CENTER_X    = DEF_CENTER_X,
  parameter logic [7:0] CENTER_Y    = DEF_CENTER_Y,
  parameter int         SERVE_TICKS = DEF_SERVE_TICKS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] pad_y_t,
  input  logic [7:0] pad_y_b,
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       hit,
  output logic       miss,
  output logic       active
);

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_serveCnt;
  logic [7:0] r_ballX;
  logic [7:0] r_ballY;
  logic       r_dxNeg;
  logic       r_dyNeg;
  logic       r_hit;
  logic       r_miss;
  logic       r_active;

  logic [7:0] w_xr;
  logic [7:0] w_yb;
  logic [7:0] w_cmpA [8];
  logic [7:0] w_cmpB [8];
  logic [7:0] w_gt;
  logic       w_atTop, w_atBot, w_atLeft, w_missCond, w_hitCond;
  logic       w_dxNegNext, w_dyNegNext;

  assign w_xr = farEdge(r_ballX, BALL_SIZE);
  assign w_yb = farEdge(r_ballY, BALL_SIZE);

  // Every check is a <= or >= form, so each one is the inverse of a single gt8.
  assign w_cmpA[0] = r_ballY;  assign w_cmpB[0] = TOP_Y;
  assign w_cmpA[1] = BOT_Y;    assign w_cmpB[1] = w_yb;
  assign w_cmpA[2] = r_ballX;  assign w_cmpB[2] = LEFT_X;
  assign w_cmpA[3] = PAD_XL;   assign w_cmpB[3] = w_xr;
  assign w_cmpA[4] = r_ballX;  assign w_cmpB[4] = PAD_XR;
  assign w_cmpA[5] = pad_y_t;  assign w_cmpB[5] = w_yb;
  assign w_cmpA[6] = r_ballY;  assign w_cmpB[6] = pad_y_b;
  assign w_cmpA[7] = MISS_X;   assign w_cmpB[7] = w_xr;

  for (genvar g = 0; g < 8; g++) begin : g_cmp
    comp_gt8 u_cmp (
      .i_a  (w_cmpA[g]),
      .i_b  (w_cmpB[g]),
      .o_gt (w_gt[g])
    );
  end

  assign w_atTop    = ~w_gt[0];
  assign w_atBot    = ~w_gt[1];
  assign w_atLeft   = ~w_gt[2];
  assign w_hitCond  = ~w_gt[3] & ~w_gt[4] & ~w_gt[5] & ~w_gt[6] & ~r_dxNeg;
  assign w_missCond = ~w_gt[7];

  assign w_dxNegNext = w_hitCond ? 1'b1 : (w_atLeft ? 1'b0 : r_dxNeg);
  assign w_dyNegNext = w_atBot   ? 1'b1 : (w_atTop  ? 1'b0 : r_dyNeg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = SERVE;
      SERVE:   if (tick && (r_serveCnt == SERVE_LAST)) w_nextState = RUN;
      RUN:     if (tick && w_missCond) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_serveCnt <= 8'd0;
      r_ballX    <= CENTER_X;
      r_ballY    <= CENTER_Y;
      r_dxNeg    <= 1'b0;
      r_dyNeg    <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_active <= (w_nextState != IDLE);
      case (r_state)
        IDLE: if (start) r_serveCnt <= 8'd0;
        SERVE: if (tick) r_serveCnt <= (r_serveCnt == SERVE_LAST) ? 8'd0 : r_serveCnt + 8'd1;
        RUN: if (tick) begin
          if (w_missCond) begin
            r_miss  <= 1'b1;
            r_ballX <= CENTER_X;
            r_ballY <= CENTER_Y;
            r_dxNeg <= 1'b0;
            r_dyNeg <= 1'b0;
          end else begin
            r_hit   <= w_hitCond;
            r_dxNeg <= w_dxNegNext;
            r_dyNeg <= w_dyNegNext;
            r_ballX <= w_dxNegNext ? r_ballX - V : r_ballX + V;
            r_ballY <= w_dyNegNext ? r_ballY - V : r_ballY + V;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_x = r_ballX;
  assign ball_y = r_ballY;
  assign hit    = r_hit;
  assign miss   = r_miss;
  assign active = r_active;

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: directed Pong scenarios plus a randomized
// phase, all compared against an arithmetic model of the ball rules.
module tb_ball_mover;

  localparam int VEL = 2, SIZE = 8, TOPW = 8, BOTW = 247, LEFTW = 8;
  localparam int PADL = 240, PADR = 243, MISSC = 250, CX = 124, CY = 124, NSERVE = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pad_y_t = 8'd0;
  logic [7:0] pad_y_b = 8'd0;
  logic [7:0] ball_x, ball_y;
  logic       hit, miss, active;

  int compareCount = 0;
  int failCount = 0;

  // Reference model: mode 0 = waiting, 1 = serving, 2 = in play.
  int mX, mY, mDx, mDy, mMode, mCnt, mHit, mMiss;

  ball_mover dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .start   (start),
    .pad_y_t (pad_y_t),
    .pad_y_b (pad_y_b),
    .ball_x  (ball_x),
    .ball_y  (ball_y),
    .hit     (hit),
    .miss    (miss),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mX = CX; mY = CY; mDx = VEL; mDy = VEL; mMode = 0; mCnt = 0; mHit = 0; mMiss = 0;
  endtask

  task automatic modelStep(input bit t, input bit s, input int pt, input int pb);
    int xr, yb;
    mHit = 0;
    mMiss = 0;
    case (mMode)
      0: if (s) begin mMode = 1; mCnt = 0; end
      1: if (t) begin
        mCnt++;
        if (mCnt == NSERVE) mMode = 2;
      end
      default: if (t) begin
        xr = mX + SIZE - 1;
        yb = mY + SIZE - 1;
        if (xr >= MISSC) begin
          mMiss = 1; mMode = 0; mX = CX; mY = CY; mDx = VEL; mDy = VEL;
        end else begin
          if (mY <= TOPW) mDy = VEL;
          if (yb >= BOTW) mDy = -VEL;
          if (mX <= LEFTW) mDx = VEL;
          if (xr >= PADL && mX <= PADR && yb >= pt && mY <= pb && mDx > 0) begin
            mDx = -VEL;
            mHit = 1;
          end
          mX += mDx;
          mY += mDy;
        end
      end
    endcase
  endtask

  task automatic compareAll();
    checkOutput("ballX", ball_x, mX);
    checkOutput("ballY", ball_y, mY);
    checkOutput("hit", hit, mHit);
    checkOutput("miss", miss, mMiss);
    checkOutput("active", active, (mMode != 0) ? 1 : 0);
  endtask

  task automatic applyStimulus(input bit t, input bit s);
    tick = t;
    start = s;
    @(posedge clk);
    modelStep(t, s, int'(pad_y_t), int'(pad_y_b));
    #1;
    compareAll();
    tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic runTick();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Asserts reset away from a clock edge and checks it takes effect before the next edge.
  task automatic doReset();
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rstX", ball_x, CX);
    checkOutput("rstY", ball_y, CY);
    checkOutput("rstActive", active, 0);
    checkOutput("rstHit", hit, 0);
    checkOutput("rstMiss", miss, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic serveToRun();
    applyStimulus(1'b0, 1'b1);
    checkOutput("serveActive", active, 1);
    for (int i = 0; i < NSERVE; i++) runTick();
    checkOutput("serveStillX", ball_x, CX);
    checkOutput("serveStillY", ball_y, CY);
  endtask

  initial begin
    int guard;
    modelReset();
    doReset();

    // Serve, then run into a tall paddle.
    pad_y_t = 8'd200;
    pad_y_b = 8'd255;
    serveToRun();
    applyStimulus(1'b1, 1'b0);
    checkOutput("firstMoveX", ball_x, 126);
    checkOutput("firstMoveY", ball_y, 126);
    applyStimulus(1'b0, 1'b0);
    for (int n = 2; n <= 55; n++) runTick();
    checkOutput("tick55X", ball_x, 234);
    applyStimulus(1'b1, 1'b0);
    checkOutput("hitPulse", hit, 1);
    checkOutput("hitX", ball_x, 232);
    checkOutput("hitY", ball_y, 236);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hitDropped", hit, 0);

    // Ride back to the left wall after the paddle return.
    guard = 0;
    while (ball_x != 8'd8 && guard < 300) begin
      runTick();
      guard++;
    end
    checkOutput("leftWallX", ball_x, 8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("leftBounceX", ball_x, 10);
    checkOutput("leftNoHit", hit, 0);
    applyStimulus(1'b0, 1'b0);

    // Paddle far from the ball: bottom bounce then a miss.
    doReset();
    pad_y_t = 8'd0;
    pad_y_b = 8'd10;
    serveToRun();
    for (int n = 1; n <= 58; n++) runTick();
    applyStimulus(1'b1, 1'b0);
    checkOutput("bounceX", ball_x, 242);
    checkOutput("bounceY", ball_y, 238);
    applyStimulus(1'b0, 1'b0);
    runTick();
    checkOutput("t60X", ball_x, 244);
    checkOutput("t60Y", ball_y, 236);
    applyStimulus(1'b1, 1'b0);
    checkOutput("missPulse", miss, 1);
    checkOutput("missX", ball_x, 124);
    checkOutput("missY", ball_y, 124);
    checkOutput("missActive", active, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("missDropped", miss, 0);

    // Ticks in IDLE are ignored; start together with tick serves with a fresh count.
    for (int i = 0; i < 3; i++) runTick();
    checkOutput("idleX", ball_x, 124);
    checkOutput("idleActive", active, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("startTickActive", active, 1);
    for (int i = 0; i < NSERVE; i++) runTick();
    checkOutput("recountX", ball_x, 124);
    runTick();
    checkOutput("recountMoveX", ball_x, 126);

    // start has no effect while running; then reset mid-play at (150,150).
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("runStartActive", active, 1);
    for (int n = 2; n <= 13; n++) runTick();
    checkOutput("midX", ball_x, 150);
    checkOutput("midY", ball_y, 150);
    doReset();

    // Randomized play with changing paddles, serves and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        pad_y_t = 8'($urandom_range(0, 255));
        pad_y_b = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 599) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
